fetch_stage: RTL

Fetch stage and FD pipeline latch of the five-stage core. Holds the architectural PC, drives the instruction-memory address, and captures fetched instructions into the FD latch. Each cycle it supplies `advanced_pc` (PC+1) to the execute-stage branch/jump control. It takes back that block's `pc_out_cont`/`BorJ` redirect, flushing wrong-path instructions and holding for hazard and multiply/divide stalls.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/cla_full_adder.sv | 59 +++++
 rtl/fetch_stage_sat_counter.sv | 32 +++
 rtl/fetch_stage.sv | 121 ++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared definitions for the fetch stage and its FD latch.
//            Provides the NOP encoding and the fetch state type.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Instruction word used for killed/empty pipeline slots.
  localparam logic [31:0] NOP = 32'd0;

  // Fetch state. The encoding is deliberate: the state bit doubles as fd_valid.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_t;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Bundle of the fetch stage's memory, control and FD latch signals.
//   master : the fetch stage (drives address_imem, advanced_pc, fd_*,
//            flush_dx and the performance counters)
//   slave  : the surrounding pipeline (drives q_imem, pc_out_cont, BorJ,
//            stall and freeze)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int IMEM_AW = 12,
  parameter int CNT_W   = 16
);

  logic [31:0]        q_imem;
  logic [31:0]        pc_out_cont;
  logic               BorJ;
  logic               stall;
  logic               freeze;
  logic [IMEM_AW-1:0] address_imem;
  logic [31:0]        advanced_pc;
  logic [31:0]        fd_pc;
  logic [31:0]        fd_ir;
  logic               fd_valid;
  logic               flush_dx;
  logic [CNT_W-1:0]   redirect_count;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    input  q_imem, pc_out_cont, BorJ, stall, freeze,
    output address_imem, advanced_pc, fd_pc, fd_ir, fd_valid, flush_dx,
           redirect_count, stall_count
  );

  modport slave (
    output q_imem, pc_out_cont, BorJ, stall, freeze,
    input  address_imem, advanced_pc, fd_pc, fd_ir, fd_valid, flush_dx,
           redirect_count, stall_count
  );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/cla_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_full_adder
// Purpose  : Carry-lookahead adder built from 4-bit groups. Group carries are
//            formed from group generate/propagate terms; carries inside a
//            group ripple. The sum wraps; no carry-out is produced.
// Ports    : i_a, i_b (WIDTH) operands, i_cin carry-in, o_sum (WIDTH) result
// Revision : 1.0 - initial release
// ============================================================================
module cla_full_adder #(
  parameter int WIDTH = 32   // multiple of 4, at least 8
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  input  wire logic             i_cin,
  output logic      [WIDTH-1:0] o_sum
);

  localparam int c_GRP  = 4;
  localparam int c_NGRP = WIDTH / c_GRP;

  logic [WIDTH-1:0]  w_p;
  logic [WIDTH-2:0]  w_g;   // generate of the top bit would only feed carry-out
  logic [WIDTH-1:0]  w_c;   // carry into each bit
  logic [c_NGRP-2:0] w_grp_g;
  logic [c_NGRP-2:0] w_grp_p;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a[WIDTH-2:0] & i_b[WIDTH-2:0];

  // Group generate/propagate for every group that feeds a following group.
  always_comb begin
    w_grp_g = '0;
    w_grp_p = '0;
    for (int k = 0; k < c_NGRP - 1; k++) begin
      w_grp_p[k] = &w_p[k*c_GRP +: c_GRP];
      for (int j = 0; j < c_GRP; j++) begin
        w_grp_g[k] = w_g[k*c_GRP + j] | (w_p[k*c_GRP + j] & w_grp_g[k]);
      end
    end
  end

  // Group boundaries take the lookahead carry; inner bits ripple.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 1; i < WIDTH; i++) begin
      if ((i % c_GRP) == 0) begin
        w_c[i] = w_grp_g[i/c_GRP - 1] | (w_grp_p[i/c_GRP - 1] & w_c[i - c_GRP]);
      end else begin
        w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
      end
    end
  end

  assign o_sum = w_p ^ w_c;

endmodule : cla_full_adder
`default_nettype wire

// File: rtl/fetch_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter; sticks at all-ones instead of wrapping.
// Ports    : clk, rst (sync active-high), i_inc count request,
//            i_hold freezes the count, o_count (CNT_W) current value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  input  wire logic             i_hold,
  output logic      [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_hold && i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Fetch stage and FD pipeline latch. Holds the PC, addresses
//            instruction memory, captures fetched words into FD, applies
//            execute-stage redirects and holds for stall/freeze.
// Ports    : clock, reset (sync active-high)
//            bus (fetch_stage_if.master):
//              in : q_imem, pc_out_cont, BorJ, stall, freeze
//              out: address_imem, advanced_pc, fd_pc, fd_ir, fd_valid,
//                   flush_dx, redirect_count, stall_count
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 12,
  parameter int          CNT_W    = 16
) (
  input  wire logic      clock,
  input  wire logic      reset,
  fetch_stage_if.master  bus
);

  logic [31:0]  r_pc;
  logic [31:0]  r_fd_ir;
  logic [31:0]  r_fd_pc;
  fetch_state_t r_state;

  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_fd_ir_nxt;
  logic [31:0]  w_fd_pc_nxt;
  fetch_state_t w_state_nxt;
  logic         w_flush;
  logic [31:0]  w_adv_pc;
  logic         w_redirect_inc;
  logic         w_stall_inc;

  cla_full_adder #(
    .WIDTH (32)
  ) u_pc_inc (
    .i_a   (r_pc),
    .i_b   (32'd1),
    .i_cin (1'b0),
    .o_sum (w_adv_pc)
  );

  // Next-state: freeze > redirect > stall > normal fetch.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_fd_ir_nxt = r_fd_ir;
    w_fd_pc_nxt = r_fd_pc;
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    if (!bus.freeze) begin
      if (bus.BorJ) begin
        // Redirect also discards any stalled FD instruction (wrong path).
        w_pc_nxt    = bus.pc_out_cont;
        w_fd_ir_nxt = NOP;
        w_fd_pc_nxt = 32'd0;
        w_state_nxt = ST_EMPTY;
        w_flush     = 1'b1;
      end else if (bus.stall) begin
        w_flush     = 1'b1;
      end else begin
        w_pc_nxt    = w_adv_pc;
        w_fd_ir_nxt = bus.q_imem;
        w_fd_pc_nxt = w_adv_pc;
        w_state_nxt = ST_FULL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_fd_ir <= NOP;
      r_fd_pc <= 32'd0;
      r_state <= ST_EMPTY;
    end else begin
      r_pc    <= w_pc_nxt;
      r_fd_ir <= w_fd_ir_nxt;
      r_fd_pc <= w_fd_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  // A redirect in the same cycle as a stall is counted only as a redirect.
  assign w_redirect_inc = bus.BorJ;
  assign w_stall_inc    = bus.stall && !bus.BorJ;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_inc   (w_redirect_inc),
    .i_hold  (bus.freeze),
    .o_count (bus.redirect_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_inc   (w_stall_inc),
    .i_hold  (bus.freeze),
    .o_count (bus.stall_count)
  );

  assign bus.address_imem = r_pc[IMEM_AW-1:0];
  assign bus.advanced_pc  = w_adv_pc;
  assign bus.fd_ir        = r_fd_ir;
  assign bus.fd_pc        = r_fd_pc;
  assign bus.fd_valid     = (r_state == ST_FULL);
  assign bus.flush_dx     = !reset && w_flush;

endmodule : fetch_stage
`default_nettype wire
